seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run-time configurable serial pattern-detection controller for the sequence-detector family. It accepts a pattern, length, mode and match target through a ready/valid configuration port, then sequences a bit-serial detection run. During the run it counts matches and stops on the target or on abort. It sits between a control master (testbench, CPU shim or upstream FSM) and a serial bit stream, replacing fixed-pattern detectors such as the 1001 non-overlapping Mealy detector.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, width of match counter and target
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  configuration accepted when high with cfg_valid
- cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last
- cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  input  CNT_W  matches before done; 0 = run until abort
- cfg_err  output  1  one-cycle pulse: illegal cfg_len rejected
- start  input  1  begin a run (level sampled; acts on rising clock edge)
- abort  input  1  terminate a run
- din  input  1  serial data bit
- din_valid  input  1  din qualifier
- dout  output  1  one-cycle match pulse
- match_count  output  CNT_W  matches in current/last run
- busy  output  1  high in RUN
- done  output  1  high in DONE

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Active config after reset: pattern 1001 (low 4 bits), len 4, overlap 0, target 0.
- Config handshake: cfg_ready = 1 in IDLE and DONE, 0 in RUN.
  - On cfg_valid & cfg_ready with cfg_len in 1..MAX_LEN, all cfg_* fields are latched.
  - With cfg_len 0 or > MAX_LEN, nothing is latched and cfg_err pulses for one cycle.
- IDLE/DONE + start (no cfg handshake that cycle) -> RUN on that edge.
  - Clears match_count, history and fill counter; dout = 0; done drops.
- If start and a cfg handshake coincide, the config is latched and start is ignored.
- RUN datapath:
  - On each edge with din_valid = 1, shift din into history LSB and increment fill (saturating at MAX_LEN).
  - Match condition: new history[len-1:0] == pattern[len-1:0] and new fill >= len.
  - On a match: dout pulses, match_count increments (saturating at all-ones).
  - Non-overlap mode: a match resets fill to 0, so the matched bits are not reused.
  - Overlap mode: fill is untouched by a match.
  - din_valid = 0: no shift, no fill change, dout = 0.
- RUN exit on target: if target != 0 and match_count reaches target on this edge -> DONE. done = 1 and busy = 0 from the next cycle.
- RUN exit on abort: abort = 1 -> IDLE. Any match on that edge is discarded: no dout, no count. match_count retains its prior value.
- DONE: holds done and match_count. din is ignored. abort -> IDLE with done cleared.
- start in RUN is ignored.

## Timing
- All outputs are registered.
- Reset values: cfg_ready 1, cfg_err 0, dout 0, match_count 0, busy 0, done 0.
- Latency: dout and the new match_count are visible the cycle after the edge that samples the final pattern bit (one-cycle Mealy-registered latency).
- busy rises the cycle after the start edge. The first din sampled in the run is on the edge after busy rises.
- done and the target-th dout pulse appear in the same cycle.
- cfg_err appears the cycle after the rejected handshake.
- Asynchronous reset mid-run immediately forces IDLE and all reset values. The config registers return to the defaults.

## Test plan
- Defaults, start, stream 1,0,0,1,0,0,1 (din_valid = 1) -> dout on 4th bit only, match_count = 1. Repeat with cfg_overlap = 1 -> dout on 4th and 7th bits, match_count = 2.
- Pattern 1001 with din_valid low for 3 cycles between bits 2 and 3 -> single dout one cycle after bit 4, no spurious pulse during gaps.
- Config pattern 8'b10110011, len 8, target 2. Stream the pattern twice back to back -> 2 pulses, done = 1 with match_count = 2. Further matching bits -> no dout.
- Abort asserted on the edge sampling the last bit of a match -> no dout, match_count unchanged, IDLE, cfg_ready = 1.
- cfg_len = 0, then cfg_len = 9 (MAX_LEN = 8) -> cfg_err pulses each time, active config unchanged (next run still detects 1001). cfg_valid during RUN -> cfg_ready = 0, not latched.
- Reset asserted mid-pattern in RUN -> all outputs at reset values immediately. After start, the stream 1,0,0,1 matches the default pattern.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Signal bundle between a control master and seq_detect_ctrl: configuration
// handshake, run control, serial stream and status.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               din;
  logic               din_valid;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, din, din_valid,
    input  cfg_ready, cfg_err, dout, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, din, din_valid,
    output cfg_ready, cfg_err, dout, match_count, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern detector: latches a pattern/length/mode/target,
// then counts matches on a bit stream until the target is reached or the run is aborted.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] next_history;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   next_fill;
  logic [CNT_W-1:0]   next_count;
  logic               cfg_fire;
  logic               cfg_legal;
  logic               hit;

  // Match evaluation on the history as it will look after shifting in din.
  always_comb begin
    cfg_fire     = bus.cfg_valid && bus.cfg_ready;
    cfg_legal    = (bus.cfg_len != '0) && (bus.cfg_len <= FILL_MAX);
    next_history = (history << 1) | MAX_LEN'(bus.din);
    next_fill    = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
    len_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    hit        = ((next_history & len_mask) == (pattern_q & len_mask)) && (next_fill >= len_q);
    next_count = (bus.match_count == CNT_MAX) ? bus.match_count : bus.match_count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pattern_q       <= MAX_LEN'(4'b1001);
      len_q           <= LEN_W'(4);
      overlap_q       <= 1'b0;
      target_q        <= '0;
      history         <= '0;
      fill            <= '0;
      bus.cfg_ready   <= 1'b1;
      bus.cfg_err     <= 1'b0;
      bus.dout        <= 1'b0;
      bus.match_count <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.cfg_err <= 1'b0;
      bus.dout    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (cfg_fire) begin
            if (cfg_legal) begin
              pattern_q <= bus.cfg_pattern;
              len_q     <= bus.cfg_len;
              overlap_q <= bus.cfg_overlap;
              target_q  <= bus.cfg_target;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
          // A configuration handshake in the same cycle takes precedence over start.
          if (state == DONE && bus.abort) begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end else if (!cfg_fire && bus.start) begin
            state           <= RUN;
            bus.busy        <= 1'b1;
            bus.cfg_ready   <= 1'b0;
            bus.done        <= 1'b0;
            bus.match_count <= '0;
            history         <= '0;
            fill            <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.cfg_ready <= 1'b1;
          end else if (bus.din_valid) begin
            history <= next_history;
            fill    <= next_fill;
            if (hit) begin
              bus.dout        <= 1'b1;
              bus.match_count <= next_count;
              if (!overlap_q) begin
                fill <= '0;
              end
              if (target_q != '0 && next_count == target_q) begin
                state         <= DONE;
                bus.done      <= 1'b1;
                bus.busy      <= 1'b0;
                bus.cfg_ready <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a bit-list reference model checked on every
// cycle, plus hand-computed spot checks at the interesting points of each scenario.
module tb_seq_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int compared   = 0;
  int mismatched = 0;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remembers every accepted bit of the run and the index of the
  // last bit consumed by a non-overlapping match.
  logic [MAX_LEN-1:0] m_pat = MAX_LEN'(9);
  int m_len   = 4;
  bit m_ovl   = 1'b0;
  int m_tgt   = 0;
  bit m_run   = 1'b0;
  bit m_done  = 1'b0;
  bit m_dout  = 1'b0;
  bit m_err   = 1'b0;
  int m_count = 0;
  int m_last  = -1;
  bit m_bits[$];

  task automatic resetModel();
    m_pat   = MAX_LEN'(9);
    m_len   = 4;
    m_ovl   = 1'b0;
    m_tgt   = 0;
    m_run   = 1'b0;
    m_done  = 1'b0;
    m_dout  = 1'b0;
    m_err   = 1'b0;
    m_count = 0;
    m_last  = -1;
    m_bits.delete();
  endtask

  task automatic stepModel();
    bit fire;
    bit ok;
    int i;
    fire   = bus.cfg_valid && !m_run;
    m_dout = 1'b0;
    m_err  = 1'b0;
    if (!m_run) begin
      if (fire) begin
        if (bus.cfg_len >= 1 && bus.cfg_len <= MAX_LEN) begin
          m_pat = bus.cfg_pattern;
          m_len = int'(bus.cfg_len);
          m_ovl = bus.cfg_overlap;
          m_tgt = int'(bus.cfg_target);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_done && bus.abort) begin
        m_done = 1'b0;
      end else if (!fire && bus.start) begin
        m_run   = 1'b1;
        m_done  = 1'b0;
        m_count = 0;
        m_last  = -1;
        m_bits.delete();
      end
    end else if (bus.abort) begin
      m_run = 1'b0;
    end else if (bus.din_valid) begin
      m_bits.push_back(bus.din);
      i  = m_bits.size() - 1;
      ok = (i + 1 >= m_len) && (m_ovl || (i - m_len + 1 > m_last));
      for (int k = 0; ok && k < m_len; k++) begin
        if (m_bits[i-k] != m_pat[k]) ok = 1'b0;
      end
      if (ok) begin
        m_dout = 1'b1;
        if (m_count < (1 << CNT_W) - 1) m_count++;
        if (!m_ovl) m_last = i;
        if (m_tgt != 0 && m_count == m_tgt) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) resetModel();
      else stepModel();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cfg_ready", bus.cfg_ready, !m_run);
      checkOutput("cfg_err", bus.cfg_err, m_err);
      checkOutput("dout", bus.dout, m_dout);
      checkOutput("match_count", bus.match_count, m_count);
      checkOutput("busy", bus.busy, m_run);
      checkOutput("done", bus.done, m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic dv, input logic st, input logic ab);
    bus.din       = d;
    bus.din_valid = dv;
    bus.start     = st;
    bus.abort     = ab;
    tick();
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic sendBits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic configure(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl, input int tgt);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
    bus.cfg_target  = CNT_W'(tgt);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.din         = 1'b0;
    bus.din_valid   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    checkOutput("reset cfg_ready", bus.cfg_ready, 1);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset match_count", bus.match_count, 0);

    $display("[TB] default pattern, non-overlapping");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("start busy", bus.busy, 1);
    sendBits(32'b1001, 4);
    checkOutput("default 4th bit dout", bus.dout, 1);
    checkOutput("default 4th bit count", bus.match_count, 1);
    sendBits(32'b001, 3);
    checkOutput("default 7th bit dout", bus.dout, 0);
    checkOutput("default final count", bus.match_count, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort idle busy", bus.busy, 0);

    $display("[TB] overlapping 1001");
    configure(8'h09, 4, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b1001001, 7);
    checkOutput("overlap 7th bit dout", bus.dout, 1);
    checkOutput("overlap count", bus.match_count, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] din_valid gaps");
    configure(8'h09, 4, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b10, 2);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(32'b01, 2);
    checkOutput("gap dout", bus.dout, 1);
    checkOutput("gap count", bus.match_count, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] 8-bit pattern with target 2");
    configure(8'hB3, 8, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'hB3B3, 16);
    checkOutput("target dout", bus.dout, 1);
    checkOutput("target done", bus.done, 1);
    checkOutput("target count", bus.match_count, 2);
    sendBits(32'hB3, 8);
    checkOutput("done ignores din dout", bus.dout, 0);
    checkOutput("done holds count", bus.match_count, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort from done", bus.done, 0);

    $display("[TB] abort on final bit");
    configure(8'h09, 4, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b100, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("abort-hit dout", bus.dout, 0);
    checkOutput("abort-hit count", bus.match_count, 0);
    checkOutput("abort-hit cfg_ready", bus.cfg_ready, 1);

    $display("[TB] illegal lengths and config during run");
    configure(8'h55, 0, 1'b1, 1);
    checkOutput("len 0 cfg_err", bus.cfg_err, 1);
    tick();
    checkOutput("cfg_err one cycle", bus.cfg_err, 0);
    configure(8'h55, 9, 1'b1, 1);
    checkOutput("len 9 cfg_err", bus.cfg_err, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b1001, 4);
    checkOutput("config kept count", bus.match_count, 1);
    configure(8'h03, 2, 1'b1, 1);
    checkOutput("run cfg_ready", bus.cfg_ready, 0);
    sendBits(32'b1001, 4);
    checkOutput("run config ignored count", bus.match_count, 2);
    checkOutput("run config ignored busy", bus.busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-run");
    configure(8'h06, 4, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b0110, 4);
    checkOutput("pre-reset count", bus.match_count, 1);
    sendBits(32'b10, 2);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", bus.busy, 0);
    checkOutput("async reset count", bus.match_count, 0);
    checkOutput("async reset cfg_ready", bus.cfg_ready, 1);
    checkOutput("async reset dout", bus.dout, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(32'b1001, 4);
    checkOutput("post-reset dout", bus.dout, 1);
    sendBits(32'b001, 3);
    checkOutput("post-reset non-overlap count", bus.match_count, 1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
